// File: rtl/muldiv_seq_div_pkg.sv
// Shared decode constants for the EX-stage sequential divider: ALU op codes,
// divider state encodings and the fixed start-to-valid latency.
package muldiv_seq_div_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_MOD = 4'd10;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_FIX  = 2'd2,
        DIV_DONE = 2'd3
    } div_state_e;

    // Cycles from the cycle presenting an accepted start to the valid cycle.
    function automatic int div_latency(input int width);
        return width + 2;
    endfunction

endpackage

// File: rtl/muldiv_seq_div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic             i_bit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic             o_qbit
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // The partial remainder stays below the divisor, so the MSB of the
    // WIDTH+1 bit trial difference is a clean borrow flag.
    assign w_shifted = {i_rem, i_bit};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    assign o_qbit    = ~w_trial[WIDTH];
    assign o_rem     = o_qbit ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_seq_div.sv
// Multi-cycle signed divide/remainder unit beside the ALU; truncating
// semantics, one restoring step per cycle on operand magnitudes.
module muldiv_seq_div
    import muldiv_seq_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] y,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic             r_mod;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_quot;
    logic [WIDTH-1:0] w_remf;

    assign w_accept = (r_state == DIV_IDLE) && start && (op == ALU_DIV || op == ALU_MOD);
    assign w_abs_a  = a[WIDTH-1] ? -a : a;
    assign w_abs_b  = b[WIDTH-1] ? -b : b;
    assign w_quot   = r_qneg ? -r_dvd : r_dvd;
    assign w_remf   = r_rneg ? -r_rem : r_rem;
    assign busy     = (r_state == DIV_CALC) || (r_state == DIV_FIX);
    assign valid    = (r_state == DIV_DONE);

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_rem     (w_rem),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= DIV_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            DIV_IDLE: if (w_accept) w_next = (b == '0) ? DIV_DONE : DIV_CALC;
            DIV_CALC: if (r_cnt == '0) w_next = DIV_FIX;
            DIV_FIX:  w_next = DIV_DONE;
            DIV_DONE: w_next = DIV_IDLE;
            default:  w_next = DIV_IDLE;
        endcase
    end

    // The dividend register doubles as the quotient: each step shifts out a
    // dividend bit at the top and shifts the new quotient bit in at the bottom.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem       <= '0;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_mod       <= 1'b0;
            r_cnt       <= '0;
            y           <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (w_accept) begin
                        r_mod <= (op == ALU_MOD);
                        if (b == '0) begin
                            y           <= (op == ALU_MOD) ? a : '1;
                            div_by_zero <= 1'b1;
                        end else begin
                            r_rem  <= '0;
                            r_dvd  <= w_abs_a;
                            r_dvs  <= w_abs_b;
                            r_qneg <= a[WIDTH-1] ^ b[WIDTH-1];
                            r_rneg <= a[WIDTH-1];
                            r_cnt  <= CW'(WIDTH - 1);
                        end
                    end
                end
                DIV_CALC: begin
                    r_rem <= w_rem;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt - CW'(1);
                end
                DIV_FIX: begin
                    y           <= r_mod ? w_remf : w_quot;
                    div_by_zero <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_div.sv
// Self-checking bench for muldiv_seq_div: directed corner cases plus random
// operands checked against a plain-arithmetic truncating-division model.
module tb_muldiv_seq_div;
    import muldiv_seq_div_pkg::*;

    localparam int W   = 32;
    localparam int LAT = div_latency(W);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [3:0]    op = ALU_ADD;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          busy;
    logic          valid;
    logic [W-1:0]  y;
    logic          div_by_zero;

    int checks = 0;
    int failures = 0;

    muldiv_seq_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .valid       (valid),
        .y           (y),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit signed arithmetic truncates toward zero and avoids
    // the most-negative / -1 overflow; the low WIDTH bits are the answer.
    function automatic logic [W-1:0] model_y(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i);
        longint sa, sb, r;
        if (b_i == '0) return (op_i == ALU_MOD) ? a_i : '1;
        sa = longint'($signed(a_i));
        sb = longint'($signed(b_i));
        r  = (op_i == ALU_MOD) ? (sa % sb) : (sa / sb);
        return r[W-1:0];
    endfunction

    // Cycle 0 presents start; lat_o counts cycles until valid (-1 on timeout).
    task automatic run_op(input logic [3:0] op_i, input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                          output logic [W-1:0] y_o, output logic dbz_o, output int lat_o,
                          output logic busy1_o, output logic busy_at_valid_o);
        int cyc;
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 1;
        busy1_o = busy;
        while (!valid && cyc < LAT + 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        y_o = y;
        dbz_o = div_by_zero;
        busy_at_valid_o = busy;
        lat_o = valid ? cyc : -1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, valid, y, div_by_zero} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got busy=%b valid=%b y=%h dbz=%b, want all 0", busy, valid, y, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] ops [8] = '{ALU_DIV, ALU_MOD, ALU_DIV, ALU_MOD, ALU_MOD, ALU_DIV, ALU_MOD, ALU_DIV};
        logic [W-1:0] as [8] = '{32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'h80000000, 32'd0};
        logic [W-1:0] bs [8] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9};
        logic [W-1:0] exp_y [8] = '{32'd14, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd1, 32'h80000000, 32'd0, 32'd0};
        logic [W-1:0] got_y;
        logic got_dbz, b1, bv;
        int lat;
        for (int i = 0; i < 8; i++) begin
            run_op(ops[i], as[i], bs[i], got_y, got_dbz, lat, b1, bv);
            checks++;
            if (got_y !== exp_y[i] || got_dbz !== 1'b0) begin
                failures++;
                $display("[TB] FAIL directed_%0d: got y=%h dbz=%b, want y=%h dbz=0", i, got_y, got_dbz, exp_y[i]);
            end
            checks++;
            if (lat != LAT || b1 !== 1'b1 || bv !== 1'b0) begin
                failures++;
                $display("[TB] FAIL directed_timing_%0d: got lat=%0d busy1=%b busy@valid=%b, want lat=%0d 1 0", i, lat, b1, bv, LAT);
            end
        end
    endtask

    task automatic test_div_by_zero();
        logic [W-1:0] got_y;
        logic got_dbz, b1, bv;
        int lat;
        run_op(ALU_DIV, 32'd5, 32'd0, got_y, got_dbz, lat, b1, bv);
        checks++;
        if (got_y !== 32'hFFFFFFFF || got_dbz !== 1'b1 || lat != 1 || b1 !== 1'b0) begin
            failures++;
            $display("[TB] FAIL dbz_div: got y=%h dbz=%b lat=%0d busy1=%b, want FFFFFFFF 1 1 0", got_y, got_dbz, lat, b1);
        end
        run_op(ALU_MOD, 32'd5, 32'd0, got_y, got_dbz, lat, b1, bv);
        checks++;
        if (got_y !== 32'd5 || got_dbz !== 1'b1 || lat != 1) begin
            failures++;
            $display("[TB] FAIL dbz_mod: got y=%h dbz=%b lat=%0d, want 5 1 1", got_y, got_dbz, lat);
        end
    endtask

    task automatic test_ignore_busy();
        int cyc, nvalid, vcyc, busy_bad;
        logic [W-1:0] vy;
        logic busy_after;
        nvalid = 0; vcyc = -1; busy_bad = 0; vy = '0; busy_after = 1'b0;
        @(negedge clk);
        start = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 45; cyc++) begin
            if (cyc < LAT && !busy) busy_bad++;
            if (cyc == LAT + 1) busy_after = busy;
            if (valid) begin
                nvalid++;
                vcyc = cyc;
                vy = y;
            end
            // Second requests land mid-calculation and in the DONE cycle.
            start = (cyc == 10 || cyc == LAT);
            a = 32'd9; b = 32'd3;
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (nvalid != 1 || vcyc != LAT || vy !== 32'd14) begin
            failures++;
            $display("[TB] FAIL ignore_busy: got valids=%0d at=%0d y=%h, want 1 at %0d y=0000000e", nvalid, vcyc, vy, LAT);
        end
        checks++;
        if (busy_bad != 0 || busy_after !== 1'b0) begin
            failures++;
            $display("[TB] FAIL ignore_busy_busy: got low_cycles=%0d busy_after_done=%b, want 0 0", busy_bad, busy_after);
        end
    endtask

    task automatic test_illegal_op();
        int seen;
        seen = 0;
        @(negedge clk);
        start = 1'b1; op = ALU_MUL; a = 32'd6; b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("[TB] FAIL illegal_op: got %0d cycles with busy/valid, want 0", seen);
        end
    endtask

    task automatic test_reset_abort();
        int nvalid;
        logic [W-1:0] got_y;
        logic got_dbz, b1, bv;
        int lat;
        nvalid = 0;
        @(negedge clk);
        start = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, valid, y, div_by_zero} !== '0) begin
            failures++;
            $display("[TB] FAIL reset_abort_async: got busy=%b valid=%b y=%h dbz=%b, want all 0", busy, valid, y, div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (valid) nvalid++;
        end
        checks++;
        if (nvalid != 0) begin
            failures++;
            $display("[TB] FAIL reset_abort_novalid: got %0d valids, want 0", nvalid);
        end
        run_op(ALU_DIV, 32'd20, 32'd4, got_y, got_dbz, lat, b1, bv);
        checks++;
        if (got_y !== 32'd5 || lat != LAT) begin
            failures++;
            $display("[TB] FAIL reset_abort_fresh: got y=%h lat=%0d, want 5 %0d", got_y, lat, LAT);
        end
    endtask

    task automatic test_random();
        logic [3:0] op_r;
        logic [W-1:0] a_r, b_r, got_y, exp_y;
        logic got_dbz, b1, bv;
        int lat, exp_lat;
        for (int i = 0; i < 40; i++) begin
            op_r = ($urandom_range(0, 1) == 0) ? ALU_DIV : ALU_MOD;
            a_r = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 300)) - W'(150) : W'($urandom);
            case ($urandom_range(0, 7))
                0:       b_r = '0;
                1, 2:    b_r = W'($urandom_range(0, 20)) - W'(10);
                default: b_r = W'($urandom) >> $urandom_range(0, 30);
            endcase
            exp_y = model_y(op_r, a_r, b_r);
            exp_lat = (b_r == '0) ? 1 : LAT;
            run_op(op_r, a_r, b_r, got_y, got_dbz, lat, b1, bv);
            checks++;
            if (got_y !== exp_y || got_dbz !== (b_r == '0) || lat != exp_lat) begin
                failures++;
                $display("[TB] FAIL random_%0d op=%0d a=%h b=%h: got y=%h dbz=%b lat=%0d, want y=%h dbz=%b lat=%0d",
                         i, op_r, a_r, b_r, got_y, got_dbz, lat, exp_y, (b_r == '0), exp_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int vcycles [$];
        int bad_y, cyc;
        bad_y = 0;
        @(negedge clk);
        start = 1'b1; op = ALU_DIV; a = 32'd100; b = 32'd7;
        for (cyc = 1; cyc <= 3 * (W + 3) + 5; cyc++) begin
            @(posedge clk); #1;
            if (valid) begin
                vcycles.push_back(cyc);
                if (y !== 32'd14) bad_y++;
            end
        end
        start = 1'b0;
        for (int k = 0; k < LAT + 5 && !valid; k++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        checks++;
        if (vcycles.size() != 3 || bad_y != 0) begin
            failures++;
            $display("[TB] FAIL back_to_back_count: got %0d valids bad_y=%0d, want 3 valids bad_y=0", vcycles.size(), bad_y);
        end else begin
            checks++;
            if (vcycles[0] != LAT || vcycles[1] != LAT + W + 3 || vcycles[2] != LAT + 2 * (W + 3)) begin
                failures++;
                $display("[TB] FAIL back_to_back_spacing: got %0d %0d %0d, want %0d %0d %0d",
                         vcycles[0], vcycles[1], vcycles[2], LAT, LAT + W + 3, LAT + 2 * (W + 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_by_zero();
        test_ignore_busy();
        test_illegal_op();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
